// File: rtl/sram_bist_march_ctrl_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
// Element tables are indexed by element number, bit 0 = E0.
package sram_bist_march_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [2:0] elem_t;

  localparam int NUM_ELEM = 6;

  // E3/E4 walk downwards; E1..E4 are read-then-write; E2/E4 read ~B; E1/E3 write ~B
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b011000;
  localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [NUM_ELEM-1:0] ELEM_RD_INV  = 6'b010100;
  localparam logic [NUM_ELEM-1:0] ELEM_WR_INV  = 6'b001010;

  function automatic logic elem_bit(input logic [NUM_ELEM-1:0] tbl, input elem_t e);
    return tbl[e];
  endfunction

endpackage

// File: rtl/sram_bist_march_seq.sv
// March C- sequencer: walks elements, ops and addresses, presenting one op per step.
// The current op is a combinational view of the registered element/op/address counters.
module sram_bist_march_seq
  import sram_bist_march_ctrl_pkg::*;
#(
  parameter int                      P_ADDR_WIDTH = 9,
  parameter int                      P_DATA_WIDTH = 8,
  parameter logic [P_DATA_WIDTH-1:0] P_BG         = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    step,
  input  logic                    abort,
  output logic                    valid,
  output logic                    we,
  output logic                    re,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic [P_DATA_WIDTH-1:0] data,
  output elem_t                   elem
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);

  logic                    active;
  elem_t                   elem_r;
  logic                    op_r;
  logic [P_ADDR_WIDTH-1:0] addr_r;

  logic  two_ops, down, we_c, inv, last_op, last_addr, last_elem, next_down;
  elem_t next_elem;

  always_comb begin
    two_ops   = elem_bit(ELEM_TWO_OPS, elem_r);
    down      = elem_bit(ELEM_DOWN, elem_r);
    // Single-op elements: E0 writes, E5 reads
    we_c      = two_ops ? op_r : (elem_r == 3'd0);
    inv       = we_c ? elem_bit(ELEM_WR_INV, elem_r) : elem_bit(ELEM_RD_INV, elem_r);
    last_op   = ~two_ops | op_r;
    last_addr = down ? (addr_r == '0) : (addr_r == ADDR_MAX);
    last_elem = (elem_r == elem_t'(NUM_ELEM - 1));
    next_elem = last_elem ? elem_r : elem_t'(elem_r + 3'd1);
    next_down = elem_bit(ELEM_DOWN, next_elem);
  end

  assign valid = active;
  assign we    = active & we_c;
  assign re    = active & ~we_c;
  assign addr  = addr_r;
  assign data  = inv ? ~P_BG : P_BG;
  assign elem  = elem_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      elem_r <= '0;
      op_r   <= 1'b0;
      addr_r <= '0;
    end else if (start) begin
      active <= 1'b1;
      elem_r <= '0;
      op_r   <= 1'b0;
      addr_r <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (step && active) begin
      if (!last_op) begin
        op_r <= 1'b1;
      end else begin
        op_r <= 1'b0;
        if (!last_addr) begin
          addr_r <= down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else if (last_elem) begin
          active <= 1'b0;
        end else begin
          elem_r <= next_elem;
          addr_r <= next_down ? ADDR_MAX : '0;
        end
      end
    end
  end

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// SRAM BIST controller: drives the macro BIST port through March C-, compares read
// data one cycle after the read edge and captures the first mismatch.
module sram_bist_march_ctrl
  import sram_bist_march_ctrl_pkg::*;
#(
  parameter int                      P_ADDR_WIDTH = 9,
  parameter int                      P_DATA_WIDTH = 8,
  parameter logic [P_DATA_WIDTH-1:0] P_BG         = 8'h00
) (
  input  logic                    A_CLK,
  input  logic                    A_RESET_N,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [P_DATA_WIDTH-1:0] fail_data,
  output logic [2:0]              fail_elem,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT,
  output state_t                  dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE; busy covers
  // the run, and done/fail/fail_* hold their values until the next accepted start.

  state_t                  state;
  logic                    seq_valid, seq_we, seq_re;
  logic [P_ADDR_WIDTH-1:0] seq_addr;
  logic [P_DATA_WIDTH-1:0] seq_data;
  elem_t                   seq_elem;

  // Expected data/element of the op on the port, then one stage later for compare
  logic [P_DATA_WIDTH-1:0] cur_exp;
  elem_t                   cur_elem;
  logic                    p_vld;
  logic [P_DATA_WIDTH-1:0] p_exp;
  logic [P_ADDR_WIDTH-1:0] p_addr;
  elem_t                   p_elem;

  logic accept, mismatch, seq_step, seq_abort;

  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign mismatch  = p_vld && (A_DOUT != p_exp);
  assign seq_step  = (state == ST_RUN) && !mismatch;
  assign seq_abort = (state == ST_RUN) && mismatch;
  assign dbg_state = state;

  sram_bist_march_seq #(
    .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_BG        (P_BG)
  ) u_seq (
    .clk  (A_CLK),
    .rst_n(A_RESET_N),
    .start(accept),
    .step (seq_step),
    .abort(seq_abort),
    .valid(seq_valid),
    .we   (seq_we),
    .re   (seq_re),
    .addr (seq_addr),
    .data (seq_data),
    .elem (seq_elem)
  );

  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      fail_elem   <= '0;
      A_BIST_EN   <= 1'b0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      A_BIST_BM   <= '0;
      cur_exp     <= '0;
      cur_elem    <= '0;
      p_vld       <= 1'b0;
      p_exp       <= '0;
      p_addr      <= '0;
      p_elem      <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_elem <= '0;
            A_BIST_EN <= 1'b1;
            A_BIST_BM <= '1;
            p_vld     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            // The op issued this cycle completes in the macro but is never compared
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            fail       <= 1'b1;
            fail_addr  <= p_addr;
            fail_data  <= A_DOUT;
            fail_elem  <= p_elem;
            A_BIST_EN  <= 1'b0;
            A_BIST_MEN <= 1'b0;
            A_BIST_WEN <= 1'b0;
            A_BIST_REN <= 1'b0;
            A_BIST_BM  <= '0;
            p_vld      <= 1'b0;
          end else begin
            A_BIST_MEN <= seq_valid;
            A_BIST_WEN <= seq_we;
            A_BIST_REN <= seq_re;
            if (seq_valid) begin
              A_BIST_ADDR <= seq_addr;
              cur_exp     <= seq_data;
              cur_elem    <= seq_elem;
              if (seq_we) A_BIST_DIN <= seq_data;
            end else begin
              state <= ST_DRAIN;
            end
            p_vld  <= A_BIST_MEN & A_BIST_REN;
            p_exp  <= cur_exp;
            p_addr <= A_BIST_ADDR;
            p_elem <= cur_elem;
          end
        end
        ST_DRAIN: begin
          if (mismatch) begin
            fail      <= 1'b1;
            fail_addr <= p_addr;
            fail_data <= A_DOUT;
            fail_elem <= p_elem;
          end
          state     <= ST_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          A_BIST_EN <= 1'b0;
          A_BIST_BM <= '0;
          p_vld     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// Bench for sram_bist_march_ctrl: behavioural 512x8 macro with injectable faults and a
// March C- op-list reference that predicts op stream, timing and first failure.
module tb_sram_bist_march_ctrl;
  import sram_bist_march_ctrl_pkg::*;

  localparam logic [7:0] B  = 8'h00;
  localparam logic [7:0] NB = 8'hFF;

  logic       A_CLK = 1'b0;
  logic       A_RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [8:0] fail_addr;
  logic [7:0] fail_data;
  logic [2:0] fail_elem;
  logic       A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
  logic [8:0] A_BIST_ADDR;
  logic [7:0] A_BIST_DIN, A_BIST_BM;
  logic [7:0] A_DOUT = 8'h00;
  state_t     dbg_state;

  sram_bist_march_ctrl #(.P_ADDR_WIDTH(9), .P_DATA_WIDTH(8), .P_BG(8'h00)) dut (
    .A_CLK(A_CLK), .A_RESET_N(A_RESET_N), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
    .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
    .A_BIST_BM(A_BIST_BM), .A_DOUT(A_DOUT), .dbg_state(dbg_state)
  );

  // Clock / cycle count (cyc = number of the most recent rising edge)
  always #5 A_CLK = ~A_CLK;
  int cyc = 0;
  always @(posedge A_CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Fault model: 0 none, 1 stuck bit on read, 2 write to 0x010 copies into 0x011
  int         fault_kind = 0;
  logic [8:0] f_addr = '0;
  int         f_bit = 0;
  logic       f_val = 1'b0;
  int         bm_bad = 0;

  function automatic logic [7:0] fault_read(input logic [8:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (fault_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // Behavioural macro: registered read data, bit-masked writes
  logic [7:0] mem [512];
  always @(posedge A_CLK) begin
    if (A_BIST_EN && A_BIST_MEN) begin
      if (A_BIST_BM !== 8'hFF) bm_bad++;
      if (A_BIST_WEN) begin
        mem[A_BIST_ADDR] = (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
        if (fault_kind == 2 && A_BIST_ADDR == 9'h010) mem[9'h011] = A_BIST_DIN;
      end else if (A_BIST_REN) begin
        A_DOUT <= fault_read(A_BIST_ADDR, mem[A_BIST_ADDR]);
      end
    end
  end

  // Observed op stream
  typedef struct {
    logic       we;
    logic       re;
    logic [8:0] addr;
    logic [7:0] din;
    int         en;
  } obs_t;
  obs_t obs_q[$];
  obs_t pass_q[$];
  always @(negedge A_CLK)
    if (A_RESET_N && A_BIST_MEN)
      obs_q.push_back('{A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, cyc});

  // Reference March C- op list
  typedef struct packed {
    logic       we;
    logic [8:0] addr;
    logic [7:0] data;
    logic [2:0] elem;
  } mop_t;
  mop_t model_q[$];

  task automatic build_model();
    logic [8:0] a;
    logic [7:0] rp;
    model_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 512; i++) begin
        a = (e == 3 || e == 4) ? 9'(511 - i) : 9'(i);
        rp = (e == 2 || e == 4) ? NB : B;
        if (e == 0) model_q.push_back('{1'b1, a, B, 3'(e)});
        else if (e == 5) model_q.push_back('{1'b0, a, B, 3'(e)});
        else begin
          model_q.push_back('{1'b0, a, rp, 3'(e)});
          model_q.push_back('{1'b1, a, ~rp, 3'(e)});
        end
      end
    end
  endtask

  // Replays the op list against the fault model; returns index of first failing read
  function automatic int ref_first_fail(output logic [8:0] fa, output logic [7:0] fd,
                                        output logic [2:0] fe);
    logic [7:0] m [512];
    logic [7:0] v;
    fa = '0; fd = '0; fe = '0;
    for (int i = 0; i < 512; i++) m[i] = 8'h00;
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i].we) begin
        m[model_q[i].addr] = model_q[i].data;
        if (fault_kind == 2 && model_q[i].addr == 9'h010) m[9'h011] = model_q[i].data;
      end else begin
        v = fault_read(model_q[i].addr, m[model_q[i].addr]);
        if (v != model_q[i].data) begin
          fa = model_q[i].addr; fd = v; fe = model_q[i].elem;
          return i;
        end
      end
    end
    return -1;
  endfunction

  // Driver tasks
  task automatic pulse_start(output int t);
    @(negedge A_CLK);
    start = 1'b1;
    obs_q.delete();
    @(negedge A_CLK);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input int budget, output int de);
    de = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge A_CLK);
      if (done === 1'b1) begin
        de = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ops(input int n);
    for (int i = 0; i < 8000 && obs_q.size() < n; i++) @(negedge A_CLK);
  endtask

  // Tests
  task automatic test_reset();
    A_RESET_N = 1'b0;
    repeat (3) @(negedge A_CLK);
    checks++;
    if ({busy, done, fail, fail_addr, fail_data, fail_elem} !== '0)
      $display("FAIL reset_status: got %0h required 0",
               {busy, done, fail, fail_addr, fail_data, fail_elem});
    checks++;
    if ({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM} !== '0)
      $display("FAIL reset_port: got %0h required 0",
               {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM});
    checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d required 0", dbg_state);
    failures += ({busy, done, fail, fail_addr, fail_data, fail_elem} !== '0) ? 1 : 0;
    failures += ({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM} !== '0) ? 1 : 0;
    failures += (dbg_state !== ST_IDLE) ? 1 : 0;
    @(negedge A_CLK);
    A_RESET_N = 1'b1;
    repeat (2) @(negedge A_CLK);
  endtask

  task automatic test_pass();
    int t, de, bad, first_bad;
    fault_kind = 0;
    bm_bad = 0;
    pulse_start(t);
    checks++;
    if (busy !== 1'b1 || A_BIST_EN !== 1'b1) begin
      failures++; $display("FAIL pass_busy_rise: got busy=%b en=%b required 1", busy, A_BIST_EN);
    end
    wait_done(6000, de);
    checks++;
    if (de !== t + 5122) begin
      failures++; $display("FAIL pass_done_edge: got %0d required %0d", de, t + 5122);
    end
    checks++;
    if ({fail, busy, A_BIST_EN, A_BIST_MEN} !== 4'b0000) begin
      failures++; $display("FAIL pass_status: got %b required 0000", {fail, busy, A_BIST_EN, A_BIST_MEN});
    end
    checks++;
    if (obs_q.size() !== 5120) begin
      failures++; $display("FAIL pass_op_count: got %0d required 5120", obs_q.size());
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < obs_q.size() && i < model_q.size(); i++) begin
      if (obs_q[i].we !== model_q[i].we || obs_q[i].re !== !model_q[i].we ||
          obs_q[i].addr !== model_q[i].addr || obs_q[i].en !== t + 1 + i ||
          (model_q[i].we && obs_q[i].din !== model_q[i].data)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL pass_op_stream: got %0d bad ops (first %0d) required 0", bad, first_bad);
    end
    checks++;
    if (bm_bad != 0) begin
      failures++; $display("FAIL pass_bitmask: got %0d non-FF ops required 0", bm_bad);
    end
    pass_q = obs_q;
  endtask

  task automatic test_down_walk();
    int bad;
    checks++;
    if (pass_q.size() < 3584) begin
      failures++; $display("FAIL down_len: got %0d required >=3584", pass_q.size());
    end else begin
      bad = 0;
      for (int j = 0; j < 1024; j++) begin
        if (pass_q[2560 + j].addr !== 9'(511 - j / 2) || pass_q[2560 + j].we !== (j % 2 == 1) ||
            (j % 2 == 1 && pass_q[2560 + j].din !== NB)) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL down_walk: got %0d bad E3 ops required 0", bad);
      end
      checks++;
      if (pass_q[2560].addr !== 9'd511 || pass_q[3583].addr !== 9'd0) begin
        failures++; $display("FAIL down_ends: got %0d..%0d required 511..0",
                             pass_q[2560].addr, pass_q[3583].addr);
      end
    end
  endtask

  task automatic test_stuck_bit();
    int t, de, idx;
    logic [8:0] fa; logic [7:0] fd; logic [2:0] fe;
    fault_kind = 1; f_addr = 9'h1A5; f_bit = 3; f_val = 1'b1;
    idx = ref_first_fail(fa, fd, fe);
    pulse_start(t);
    wait_done(6000, de);
    repeat (3) @(negedge A_CLK);
    checks++;
    if ({fail, fail_addr, fail_data, fail_elem} !== {1'b1, 9'h1A5, 8'h08, 3'd1}) begin
      failures++; $display("FAIL stuck_capture: got fail=%b addr=%0h data=%0h elem=%0d required 1/1a5/08/1",
                           fail, fail_addr, fail_data, fail_elem);
    end
    checks++;
    if (de !== t + 3 + idx) begin
      failures++; $display("FAIL stuck_done_edge: got %0d required %0d", de, t + 3 + idx);
    end
    checks++;
    if (obs_q.size() !== idx + 2) begin
      failures++; $display("FAIL stuck_op_count: got %0d required %0d", obs_q.size(), idx + 2);
    end
  endtask

  task automatic test_coupling();
    int t, de, idx;
    logic [8:0] fa; logic [7:0] fd; logic [2:0] fe;
    fault_kind = 2;
    idx = ref_first_fail(fa, fd, fe);
    pulse_start(t);
    wait_done(6000, de);
    checks++;
    if ({fail, fail_addr, fail_data, fail_elem} !== {1'b1, 9'h011, 8'hFF, 3'd1}) begin
      failures++; $display("FAIL coupling_capture: got fail=%b addr=%0h data=%0h elem=%0d required 1/011/ff/1",
                           fail, fail_addr, fail_data, fail_elem);
    end
    checks++;
    if (de !== t + 3 + idx) begin
      failures++; $display("FAIL coupling_done_edge: got %0d required %0d", de, t + 3 + idx);
    end
  endtask

  task automatic test_random_faults();
    int t, de, idx;
    logic [8:0] fa; logic [7:0] fd; logic [2:0] fe;
    for (int it = 0; it < 4; it++) begin
      fault_kind = 1;
      f_addr = 9'($urandom_range(0, 511));
      f_bit = $urandom_range(0, 7);
      f_val = 1'($urandom_range(0, 1));
      idx = ref_first_fail(fa, fd, fe);
      pulse_start(t);
      wait_done(6000, de);
      repeat (2) @(negedge A_CLK);
      checks++;
      if ({fail, fail_addr, fail_data, fail_elem} !== {1'b1, fa, fd, fe}) begin
        failures++; $display("FAIL rand_capture[%0d]: got %0h/%0h/%0h/%0d required 1/%0h/%0h/%0d",
                             it, fail, fail_addr, fail_data, fail_elem, fa, fd, fe);
      end
      checks++;
      if (de !== t + 3 + idx || obs_q.size() !== idx + 2) begin
        failures++; $display("FAIL rand_timing[%0d]: got edge %0d ops %0d required edge %0d ops %0d",
                             it, de, obs_q.size(), t + 3 + idx, idx + 2);
      end
    end
  endtask

  task automatic test_restart_ignore();
    int t, de;
    fault_kind = 2;
    pulse_start(t);
    wait_done(6000, de);
    checks++;
    if (fail !== 1'b1) begin
      failures++; $display("FAIL restart_pre_fail: got %b required 1", fail);
    end
    fault_kind = 0;
    pulse_start(t);
    checks++;
    if ({done, fail, fail_addr, fail_data, fail_elem, busy} !== {28'h0, 1'b1}) begin
      failures++; $display("FAIL restart_clear: got done=%b fail=%b addr=%0h data=%0h elem=%0d busy=%b required all 0, busy 1",
                           done, fail, fail_addr, fail_data, fail_elem, busy);
    end
    wait_ops(100);
    start = 1'b1;
    @(negedge A_CLK);
    start = 1'b0;
    wait_done(6000, de);
    checks++;
    if (de !== t + 5122 || fail !== 1'b0 || obs_q.size() !== 5120) begin
      failures++; $display("FAIL ignore_start: got edge %0d fail %b ops %0d required edge %0d fail 0 ops 5120",
                           de, fail, obs_q.size(), t + 5122);
    end
  endtask

  task automatic test_async_reset();
    int t, de;
    fault_kind = 0;
    pulse_start(t);
    wait_ops(2000);
    #2 A_RESET_N = 1'b0;
    #1;
    checks++;
    if ({busy, done, fail, fail_addr, fail_data, fail_elem, A_BIST_EN, A_BIST_MEN, A_BIST_WEN,
         A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM} !== '0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL async_reset: got busy=%b en=%b men=%b addr=%0h state=%0d required all 0",
                           busy, A_BIST_EN, A_BIST_MEN, A_BIST_ADDR, dbg_state);
    end
    @(negedge A_CLK);
    A_RESET_N = 1'b1;
    @(negedge A_CLK);
    pulse_start(t);
    wait_done(6000, de);
    checks++;
    if (de !== t + 5122 || fail !== 1'b0 || obs_q.size() !== 5120) begin
      failures++; $display("FAIL reset_rerun: got edge %0d fail %b ops %0d required edge %0d fail 0 ops 5120",
                           de, fail, obs_q.size(), t + 5122);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_pass();
    test_down_walk();
    test_stuck_bit();
    test_coupling();
    test_random_faults();
    test_restart_ignore();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
